// File: rtl/instr_enc_pkg.sv
// Shared encodings for the instruction stream encoder: op classes, DP command codes,
// branch prefix and the FSM state type.
package instr_enc_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;

  localparam logic [3:0] COND_AL   = 4'hE;
  localparam logic [3:0] BR_PREFIX = 4'b1010;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} enc_state_t;

  function automatic logic dp_cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer for the ARM-subset word format.
// Legality checking is compiled in only when INSTR_ENC_CHECK_EN is defined.
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  input  logic [23:0] broff,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word = {cond, op, funct, rn, rd, src2};
    if (op == OP_BR) word = {cond, BR_PREFIX, broff};
  end

`ifdef INSTR_ENC_CHECK_EN
  // DP funct is {I,cmd,S}; MEM funct is {~I,P,U,B,W,L}
  always_comb begin
    legal = 1'b1;
    case (op)
      OP_ILL: legal = 1'b0;
      OP_DP: begin
        if (!dp_cmd_legal(funct[4:1])) legal = 1'b0;
        if (((funct[4:1] == CMD_CMP) || (funct[4:1] == CMD_CMN)) && !funct[0]) legal = 1'b0;
      end
      OP_MEM: if (!funct[4] || funct[2] || funct[1]) legal = 1'b0;
      default: legal = 1'b1;
    endcase
  end
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/instr_stream_encoder.sv
// Accepts field-level instructions over valid/ready and writes packed words to instruction RAM.
// Optional legality check and sticky Err flag enabled by defining INSTR_ENC_CHECK_EN.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InLast,
  input  logic [3:0]        Cond,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic [3:0]        Rn,
  input  logic [3:0]        Rd,
  input  logic [11:0]       Src2,
  input  logic [23:0]       BrOff,
  output logic              InstrWE,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic [31:0]       InstrWD,
  output logic [ADDR_W:0]   Count,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  enc_state_t      state_q, state_d;
  logic [ADDR_W:0] count_q;
  logic            hs, we, full;

  logic [3:0]  cond_p0, rn_p0, rd_p0;
  logic [1:0]  op_p0;
  logic [5:0]  funct_p0;
  logic [11:0] src2_p0;
  logic [23:0] broff_p0;
  logic        last_p0;

  logic [31:0] word_p0;
  logic        legal_p0;

  assign hs = InReady && InValid;

  // Stage p0: bundle captured on handshake
  always_ff @(posedge CLK) begin
    if (hs) begin
      cond_p0  <= Cond;
      op_p0    <= Op;
      funct_p0 <= Funct;
      rn_p0    <= Rn;
      rd_p0    <= Rd;
      src2_p0  <= Src2;
      broff_p0 <= BrOff;
      last_p0  <= InLast;
    end
  end

  instr_pack u_pack (
    .cond  (cond_p0),
    .op    (op_p0),
    .funct (funct_p0),
    .rn    (rn_p0),
    .rd    (rd_p0),
    .src2  (src2_p0),
    .broff (broff_p0),
    .word  (word_p0),
    .legal (legal_p0)
  );

  // Memory fills when the count after this write reaches DEPTH
  assign full = (count_q + {{ADDR_W{1'b0}}, we}) == DEPTH_C;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (Start) begin
      state_d = ACCEPT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCEPT:  if (InValid) state_d = WRITE;
        WRITE:   state_d = (last_p0 || full) ? DONE : ACCEPT;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    InReady = (state_q == ACCEPT) && !Start;
    we      = (state_q == WRITE) && legal_p0;
    InstrWE = we;
    InstrWD = (state_q == WRITE) ? word_p0 : 32'h0;
    Done    = (state_q == DONE);
  end

  // A Start coinciding with WRITE lets the write out but restarts the count
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  count_q <= '0;
    else if (Start) count_q <= '0;
    else if (we)    count_q <= count_q + 1'b1;
  end

  assign Count     = count_q;
  assign InstrAddr = BASE_ADDR + count_q[ADDR_W-1:0];

`ifdef INSTR_ENC_CHECK_EN
  logic err_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                               err_q <= 1'b0;
    else if (Start)                             err_q <= 1'b0;
    else if ((state_q == WRITE) && !legal_p0)   err_q <= 1'b1;
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: directed examples, random programs,
// Start/handshake collision, memory-full and mid-write reset.
module tb_instr_stream_encoder;

  localparam int                AW    = 3;
  localparam int                DEPTH = 1 << AW;
  localparam logic [AW-1:0]     BASE  = 3'd5;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          Start = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic          InLast = 1'b0;
  logic [3:0]    Cond = '0;
  logic [1:0]    Op = '0;
  logic [5:0]    Funct = '0;
  logic [3:0]    Rn = '0;
  logic [3:0]    Rd = '0;
  logic [11:0]   Src2 = '0;
  logic [23:0]   BrOff = '0;
  logic          InstrWE;
  logic [AW-1:0] InstrAddr;
  logic [31:0]   InstrWD;
  logic [AW:0]   Count;
  logic          Done;
  logic          Err;

  instr_stream_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .InValid(InValid), .InReady(InReady),
    .InLast(InLast), .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2),
    .BrOff(BrOff), .InstrWE(InstrWE), .InstrAddr(InstrAddr), .InstrWD(InstrWD),
    .Count(Count), .Done(Done), .Err(Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference program state: writes so far, program finished, illegal seen
  int   m_n = 0;
  bit   m_done = 0;
  bit   m_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [3:0] c, input logic [1:0] o,
      input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
      input logic [11:0] s, input logic [23:0] b);
    if (o == 2'b10) return {c, 4'b1010, b};
    return {c, o, f, n, d, s};
  endfunction

  function automatic bit model_legal(input logic [1:0] o, input logic [5:0] f);
`ifdef INSTR_ENC_CHECK_EN
    logic [3:0] cmd;
    cmd = f[4:1];
    if (o == 2'b11) return 0;
    if (o == 2'b00) begin
      if (!(cmd inside {4'd0, 4'd2, 4'd4, 4'd12, 4'd10, 4'd11})) return 0;
      if ((cmd == 4'd10 || cmd == 4'd11) && !f[0]) return 0;
    end
    if (o == 2'b01 && (!f[4] || f[2] || f[1])) return 0;
    return 1;
`else
    return (o != 2'b11) || 1'b1;
`endif
  endfunction

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge CLK) begin
    if (RESET_N && InstrWE) begin
      if (q.size() == 0) begin
        chk("unexpected_we", 64'(InstrWD), 64'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 64'(InstrAddr), 64'(e.addr));
        chk("wr_data", 64'(InstrWD), 64'(e.wd));
        chk("wr_count", 64'(Count), 64'(e.cnt));
      end
    end
  end

  task automatic model_start();
    m_n = 0; m_done = 0; m_err = 0;
  endtask

  task automatic start_prog();
    @(posedge CLK); #1 Start = 1'b1;
    @(posedge CLK); #1 Start = 1'b0;
    model_start();
  endtask

  task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
      input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
      input logic [23:0] b, input logic last);
    bit accepted, expect_acc;
    exp_t e;
    expect_acc = !m_done;
    Cond = c; Op = o; Funct = f; Rn = n; Rd = d; Src2 = s; BrOff = b; InLast = last;
    InValid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 8 && !accepted; i++) begin
      @(negedge CLK);
      if (InReady) begin
        accepted = 1;
        if (model_legal(o, f)) begin
          e.addr = AW'((int'(BASE) + m_n) % DEPTH);
          e.wd   = model_word(c, o, f, n, d, s, b);
          e.cnt  = (AW+1)'(m_n);
          q.push_back(e);
          m_n++;
        end else begin
          m_err = 1;
        end
        if (last || m_n == DEPTH) m_done = 1;
      end
      @(posedge CLK); #1;
    end
    InValid = 1'b0; InLast = 1'b0;
    chk("handshake", 64'(accepted), 64'(expect_acc));
  endtask

  task automatic check_end(input string nm);
    repeat (2) @(posedge CLK);
    #1;
    chk({nm, "_done"}, 64'(Done), 64'(m_done));
    chk({nm, "_count"}, 64'(Count), 64'(m_n));
    chk({nm, "_err"}, 64'(Err), 64'(m_err));
    if (m_done) chk({nm, "_ready"}, 64'(InReady), 64'd0);
    chk({nm, "_drain"}, 64'(q.size()), 64'd0);
  endtask

  task automatic send_random(input logic last);
    logic [1:0] o;
`ifdef INSTR_ENC_CHECK_EN
    o = 2'($urandom_range(0, 3));
`else
    o = 2'($urandom_range(0, 2));
`endif
    send(4'($urandom), o, 6'($urandom), 4'($urandom), 4'($urandom),
         12'($urandom), 24'($urandom), last);
  endtask

  initial begin
    int len;
    #12;
    chk("rst_ready", 64'(InReady), 64'd0);
    chk("rst_we", 64'(InstrWE), 64'd0);
    chk("rst_addr", 64'(InstrAddr), 64'(BASE));
    chk("rst_wd", 64'(InstrWD), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_err", 64'(Err), 64'd0);
    @(posedge CLK); #1 RESET_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("idle_ready", 64'(InReady), 64'd0);

    // ADD R1,R2,#5 ; LDR R3,[R4,#-8] ; B -2
    start_prog();
    send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    send(4'hE, 2'b01, 6'b010001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b0);
    send(4'hE, 2'b10, 6'b000000, 4'd0, 4'd0, 12'h000, 24'hFFFFFE, 1'b1);
    check_end("directed");
    chk("word_add", 64'(model_word(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0)), 64'hE2821005);

`ifdef INSTR_ENC_CHECK_EN
    start_prog();
    send(4'hE, 2'b00, 6'b110100, 4'd1, 4'd0, 12'h003, 24'h0, 1'b0);
    send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1);
    check_end("illegal_cmp");
`endif

    // Memory full: more bundles than DEPTH, extra ones never handshake
    start_prog();
    for (int i = 0; i < DEPTH + 2; i++)
      send(4'hE, 2'b00, 6'b101000, 4'(i), 4'(i + 1), 12'(i * 3), 24'h0, 1'b0);
    check_end("full");

    // Start coinciding with a valid bundle must not accept it
    start_prog();
    @(posedge CLK); #1;
    Cond = 4'h1; Op = 2'b10; BrOff = 24'h123456; InValid = 1'b1; Start = 1'b1;
    @(negedge CLK);
    chk("start_blocks_ready", 64'(InReady), 64'd0);
    @(posedge CLK); #1 Start = 1'b0;
    model_start();
    send(4'h1, 2'b10, 6'h0, 4'h0, 4'h0, 12'h0, 24'h123456, 1'b1);
    check_end("start_collide");

    // Random programs, some longer than the memory
    for (int p = 0; p < 10; p++) begin
      start_prog();
      len = $urandom_range(1, DEPTH + 3);
      for (int i = 0; i < len; i++) send_random(i == len - 1);
      check_end("random");
    end

    // Reset while a write is on the bus
    start_prog();
    send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0);
    Cond = 4'hE; Op = 2'b10; BrOff = 24'h000010; InValid = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
        @(negedge CLK);
        if (InReady) seen = 1;
        @(posedge CLK); #1;
      end
      InValid = 1'b0;
      chk("rst_mid_hs", 64'(seen), 64'd1);
    end
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_mid_we", 64'(InstrWE), 64'd0);
    chk("rst_mid_count", 64'(Count), 64'd0);
    q.delete();
    model_start();
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rel_ready", 64'(InReady), 64'd0);
    chk("rst_rel_done", 64'(Done), 64'd0);

    start_prog();
    send_random(1'b1);
    check_end("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
